// File: rtl/hamming_encoder_tx.sv
// (15,11) Hamming transmit encoder: accepts 11-bit words over valid/ready, builds the
// codeword (parity at indices 0,1,3,7), optionally flips one bit, then streams it serially.
module hamming_encoder_tx #(
    parameter bit MSB_FIRST = 1'b0,
    parameter int COUNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENC_IN_VALID,
    output logic               ENC_IN_READY,
    input  logic [10:0]        ENC_INPUT,
    input  logic               ERR_INJ_EN,
    input  logic [3:0]         ERR_POS,
    output logic [14:0]        ENC_CODEWORD,
    output logic               SER_OUT,
    output logic               SER_VALID,
    input  logic               SER_READY,
    output logic               SER_FIRST,
    output logic               SER_LAST,
    output logic               ENC_BUSY,
    output logic [COUNT_W-1:0] WORD_COUNT
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // Data bits occupy every codeword index whose 1-based position is not a power of two.
    localparam int          DATA_POS [11] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
    localparam int          PAR_POS  [4]  = '{0, 1, 3, 7};
    localparam logic [14:0] PAR_MASK [4]  = '{15'h5555, 15'h6666, 15'h7878, 15'h7F80};

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [14:0]          shift_q;
    logic [14:0]          codeword_q;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_d;

    logic [14:0]          data_cw;
    logic [3:0]           par_bits;
    logic [14:0]          full_cw;
    logic [14:0]          flip_mask;
    logic [14:0]          inj_cw;
    logic [14:0]          ordered;
    logic                 busy;
    logic                 last_handshake;
    logic                 accept;

    genvar gi;

    generate
        for (gi = 0; gi < 11; gi++) begin : g_data
            assign data_cw[DATA_POS[gi]] = ENC_INPUT[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_par
            assign data_cw[PAR_POS[gi]] = 1'b0;
            assign par_bits[gi]         = ^(data_cw & PAR_MASK[gi]);
        end
    endgenerate

    always_comb begin
        full_cw = data_cw;
        for (int k = 0; k < 4; k++) begin
            full_cw[PAR_POS[k]] = par_bits[k];
        end
    end

    // ERR_POS of 15 falls outside the codeword and therefore never flips anything.
    assign flip_mask = (ERR_INJ_EN && (ERR_POS != 4'd15)) ? (15'd1 << ERR_POS) : 15'd0;
    assign inj_cw    = full_cw ^ flip_mask;

    generate
        for (gi = 0; gi < 15; gi++) begin : g_order
            assign ordered[gi] = MSB_FIRST ? shift_q[14 - gi] : shift_q[gi];
        end
    endgenerate

    assign busy           = (state_q == ST_SHIFT);
    assign last_handshake = busy && (idx_q == 4'd14) && SER_READY;
    assign ENC_IN_READY   = !RST && ((state_q == ST_IDLE) || last_handshake);
    assign accept         = ENC_IN_VALID && ENC_IN_READY;
    assign count_d        = count_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            shift_q    <= 15'd0;
            codeword_q <= 15'd0;
            count_q    <= '0;
        end else if (accept) begin
            state_q    <= ST_SHIFT;
            idx_q      <= 4'd0;
            shift_q    <= inj_cw;
            codeword_q <= inj_cw;
            count_q    <= count_d;
        end else if (busy && SER_READY) begin
            if (idx_q == 4'd14) begin
                state_q <= ST_IDLE;
                idx_q   <= 4'd0;
            end else begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    assign ENC_CODEWORD = codeword_q;
    assign WORD_COUNT   = count_q;
    assign ENC_BUSY     = busy;
    assign SER_VALID    = busy;
    assign SER_OUT      = busy && ordered[idx_q];
    assign SER_FIRST    = busy && (idx_q == 4'd0);
    assign SER_LAST     = busy && (idx_q == 4'd14);

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Bench for hamming_encoder_tx: LSB-first/16-bit-count and MSB-first/4-bit-count instances
// share stimulus and are compared every cycle against a position/syndrome based model.
module tb_hamming_encoder_tx;

    logic        clk = 1'b0;
    logic        rst, in_valid, inj_en, ser_ready;
    logic [10:0] in_data;
    logic [3:0]  err_pos;

    logic        a_ready, a_sout, a_svalid, a_sfirst, a_slast, a_busy;
    logic [14:0] a_cw;
    logic [15:0] a_count;
    logic        b_ready, b_sout, b_svalid, b_sfirst, b_slast, b_busy;
    logic [14:0] b_cw;
    logic [3:0]  b_count;

    always #5 clk = ~clk;

    hamming_encoder_tx #(.MSB_FIRST(1'b0), .COUNT_W(16)) dut_a (
        .CLK(clk), .RST(rst), .ENC_IN_VALID(in_valid), .ENC_IN_READY(a_ready),
        .ENC_INPUT(in_data), .ERR_INJ_EN(inj_en), .ERR_POS(err_pos),
        .ENC_CODEWORD(a_cw), .SER_OUT(a_sout), .SER_VALID(a_svalid),
        .SER_READY(ser_ready), .SER_FIRST(a_sfirst), .SER_LAST(a_slast),
        .ENC_BUSY(a_busy), .WORD_COUNT(a_count)
    );

    hamming_encoder_tx #(.MSB_FIRST(1'b1), .COUNT_W(4)) dut_b (
        .CLK(clk), .RST(rst), .ENC_IN_VALID(in_valid), .ENC_IN_READY(b_ready),
        .ENC_INPUT(in_data), .ERR_INJ_EN(inj_en), .ERR_POS(err_pos),
        .ENC_CODEWORD(b_cw), .SER_OUT(b_sout), .SER_VALID(b_svalid),
        .SER_READY(ser_ready), .SER_FIRST(b_sfirst), .SER_LAST(b_slast),
        .ENC_BUSY(b_busy), .WORD_COUNT(b_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit          m_active = 1'b0;
    logic [14:0] m_frame  = 15'd0;
    logic [14:0] m_cw     = 15'd0;
    int          m_k      = 0;
    int unsigned m_count  = 0;
    bit          acc_seen = 1'b0;
    int          sv_run   = 0;
    int          sv_max   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Syndrome view: XOR of 1-based positions of all set bits must be zero.
    function automatic logic [3:0] syndrome(input logic [14:0] cw);
        logic [3:0] s = 4'd0;
        for (int p = 1; p <= 15; p++) if (cw[p-1]) s ^= 4'(p);
        return s;
    endfunction

    function automatic logic [14:0] model_encode(input logic [10:0] d, input logic inj,
                                                 input logic [3:0] pos);
        logic [14:0] cw = 15'd0;
        logic [3:0]  s;
        int          j  = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        s = syndrome(cw);
        for (int k = 0; k < 4; k++) cw[(1 << k) - 1] = s[k];
        if (inj && pos != 4'd15) cw[pos] = ~cw[pos];
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [14:0] cw);
        logic [10:0] d = 11'd0;
        int          j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = cw[p-1];
                j++;
            end
        end
        return d;
    endfunction

    // Compare on the falling edge, then advance the model to what the next rising edge does.
    initial forever begin
        logic       exp_ready;
        logic [5:0] ea, eb;
        @(negedge clk);
        exp_ready = !rst && (!m_active || (m_k == 14 && ser_ready));
        ea = {m_active, m_active && m_frame[m_k], m_active && m_k == 0,
              m_active && m_k == 14, m_active, exp_ready};
        eb = {m_active, m_active && m_frame[14 - m_k], m_active && m_k == 0,
              m_active && m_k == 14, m_active, exp_ready};
        check("a_status", 32'({a_svalid, a_sout, a_sfirst, a_slast, a_busy, a_ready}), 32'(ea));
        check("b_status", 32'({b_svalid, b_sout, b_sfirst, b_slast, b_busy, b_ready}), 32'(eb));
        check("a_codeword", 32'(a_cw), 32'(m_cw));
        check("b_codeword", 32'(b_cw), 32'(m_cw));
        check("a_count", 32'(a_count), 32'(m_count[15:0]));
        check("b_count", 32'(b_count), 32'(m_count[3:0]));
        if (a_svalid) sv_run++; else sv_run = 0;
        if (sv_run > sv_max) sv_max = sv_run;
        acc_seen = in_valid && exp_ready;
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_count  = 0;
            m_cw     = 15'd0;
        end else begin
            if (m_active && ser_ready) begin
                if (m_k == 14) begin
                    m_active = 1'b0;
                    m_k      = 0;
                end else begin
                    m_k++;
                end
            end
            if (acc_seen) begin
                m_frame  = model_encode(in_data, inj_en, err_pos);
                m_cw     = m_frame;
                m_count++;
                m_active = 1'b1;
                m_k      = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (acc_seen) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [10:0] d, input logic inj, input logic [3:0] pos);
        in_data  = d;
        inj_en   = inj;
        err_pos  = pos;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        inj_en   = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (!a_busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          t_acc;
        int          n;
        logic [2:0]  held;
        rst = 1'b1; in_valid = 1'b0; inj_en = 1'b0; ser_ready = 1'b1;
        in_data = 11'd0; err_pos = 4'd15;
        repeat (3) tick();
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_outputs", 32'({a_svalid, a_sout, a_busy, a_cw}), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(a_ready), 32'd1);

        check("model_000", 32'(model_encode(11'h000, 1'b0, 4'd15)), 32'h0000);
        check("model_001", 32'(model_encode(11'h001, 1'b0, 4'd15)), 32'h0007);
        check("model_400", 32'(model_encode(11'h400, 1'b0, 4'd15)), 32'h408B);
        check("model_7ff", 32'(model_encode(11'h7FF, 1'b0, 4'd15)), 32'h7FFF);
        check("model_inj2", 32'(model_encode(11'h001, 1'b1, 4'd2)), 32'h0003);

        send_word(11'h000, 1'b0, 4'd15); check("cw_000", 32'(a_cw), 32'h0000); wait_idle();
        send_word(11'h001, 1'b0, 4'd15); check("cw_001", 32'(a_cw), 32'h0007); wait_idle();
        send_word(11'h400, 1'b0, 4'd15); check("cw_400", 32'(a_cw), 32'h408B); wait_idle();
        send_word(11'h7FF, 1'b0, 4'd15); check("cw_7ff", 32'(b_cw), 32'h7FFF); wait_idle();
        send_word(11'h001, 1'b1, 4'd2);  check("cw_inj2", 32'(a_cw), 32'h0003); wait_idle();
        send_word(11'h001, 1'b1, 4'd15); check("cw_inj15", 32'(a_cw), 32'h0007); wait_idle();

        // Back-to-back frames with the source always valid.
        do_reset();
        sv_max   = 0;
        in_valid = 1'b1;
        t_acc    = 0;
        for (int w = 0; w < 3; w++) begin
            in_data = 11'($urandom);
            wait_accept();
            if (w > 0) check("b2b_gap", cyc - t_acc, 32'd15);
            t_acc = cyc;
        end
        in_valid = 1'b0;
        wait_idle();
        tick();
        check("b2b_valid_run", sv_max, 32'd45);
        check("b2b_count", 32'(a_count), 32'd3);

        // Stall for five cycles at bit index 7.
        send_word(11'($urandom), 1'b0, 4'd15);
        repeat (7) tick();
        ser_ready = 1'b0;
        held = {a_sout, a_sfirst, a_slast};
        for (int s = 0; s < 5; s++) begin
            tick();
            check("stall_hold", 32'({a_sout, a_sfirst, a_slast, a_svalid}), 32'({held, 1'b1}));
        end
        ser_ready = 1'b1;
        n = 0;
        while (a_busy && n < 100) begin
            tick();
            n++;
        end
        check("stall_tail", n, 32'd8);

        // Reset in the middle of a frame at index 9.
        send_word(11'($urandom), 1'b0, 4'd15);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_status", 32'({a_svalid, a_sout, a_sfirst, a_slast, a_busy, a_ready}), 32'd0);
        check("rst_mid_cw", 32'(a_cw), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(a_ready), 32'd1);
        send_word(11'($urandom), 1'b0, 4'd15);
        check("rst_restart_first", 32'({a_svalid, a_sfirst}), 32'd3);
        wait_idle();

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int w = 0; w < 17; w++) begin
            send_word(11'($urandom), 1'b0, 4'd15);
            wait_idle();
        end
        check("wrap_count_b", 32'(b_count), 32'd1);
        check("wrap_count_a", 32'(a_count), 32'd17);

        // Randomised traffic with back-pressure, injection and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if (!in_valid || acc_seen) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 11'($urandom);
                inj_en   = ($urandom_range(0, 3) == 0);
                err_pos  = 4'($urandom);
            end
            ser_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; inj_en = 1'b0; ser_ready = 1'b1;
        wait_idle();

        // Every data word, decoded back from the parallel codeword.
        do_reset();
        in_valid = 1'b1;
        for (int d = 0; d < 2048; d++) begin
            in_data = 11'(d);
            wait_accept();
            check("loop_syndrome", 32'(syndrome(a_cw)), 32'd0);
            check("loop_data", 32'(extract(a_cw)), d);
        end
        in_valid = 1'b0;
        wait_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
